pcm_stream_feeder: RTL and testbench
====================================

Name: pcm_stream_feeder

Overview:
- Upstream source for the audio output stage. Buffers a host-written PCM byte stream (16-bit signed little-endian stereo, L then R) in a byte FIFO.
- Pops bytes on the DAC's next_byte strobes and assembles one stereo frame per next_sample strobe.
- Drives snd_l, snd_r and snd_on in the form the DAC/volume/mute chain consumes.
- Handles underrun, overflow and frame alignment so the downstream fade logic sees clean, whole frames.

Parameters:
- DEPTH_LOG2, 10, FIFO depth is 2^DEPTH_LOG2 bytes.
- OFF_FRAMES, 16, number of consecutive underrun frames before snd_on deasserts.
- ZERO_ON_OFF, 1, when 1, snd_l and snd_r are forced to 0 when snd_on falls; when 0, the last sample is held.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- enable  in  1  stream playback enable.
- flush  in  1  single-cycle pulse; empties the FIFO.
- wr_en  in  1  host byte write strobe.
- wr_data  in  8  host byte.
- next_byte  in  1  DAC byte-fetch strobe, one clk wide. Four per frame.
- next_sample  in  1  DAC frame strobe, one clk wide, after the 4th next_byte.
- snd_l  out  16  signed left sample.
- snd_r  out  16  signed right sample.
- snd_on  out  1  stream active.
- fifo_full  out  1  FIFO full.
- fifo_level  out  DEPTH_LOG2+1  bytes currently stored.
- overflow  out  1  sticky; a write was dropped while full. Cleared by flush.
- underrun_ctr  out  8  saturating count of underrun frames. Cleared by flush.

Behaviour:
- Reset (async, rst_n=0): every output is 0, the FIFO is empty, slot=0, frame_ok=0, off counter=0.
- FIFO:
  - A write while full is dropped and sets overflow.
  - A write and a pop in the same cycle leave fifo_level unchanged.
  - Read data is registered: a byte is valid one clk after its pop.
  - next_byte strobes are at least 2 clk apart, so there is no read hazard.
- Slot counter (2 bits), advanced on next_byte:
  - Slot 0 = L lo, 1 = L hi, 2 = R lo, 3 = R hi.
  - On slot 0, frame_ok is set only if enable=1 and fifo_level>=4. fifo_level is sampled before any same-cycle write.
  - If frame_ok is set, pop on slots 0–3. If it is not set, there are no pops for the whole frame, which preserves byte alignment of the stream.
  - Popped bytes are captured into a 32-bit assembly register.
- On next_sample (the registered update is visible 1 clk later):
  - If frame_ok, with all 4 bytes captured: snd_l = {b1,b0}, snd_r = {b3,b2}; snd_on=1; off counter=0.
  - Otherwise, underrun: underrun_ctr increments and saturates at 255, and the outputs hold their values.
    - The off counter increments. When it reaches OFF_FRAMES, snd_on=0, and if ZERO_ON_OFF=1, snd_l and snd_r become 0.
  - In both cases slot is reset to 0 and frame_ok is cleared.
- If next_sample and next_byte arrive in the same cycle, next_sample is processed first, then next_byte is treated as slot 0 of the new frame.
- next_byte beyond slot 3 before next_sample: ignored, no pop.
- enable=0:
  - No new frames commit.
  - snd_on drops on the next next_sample.
  - The FIFO contents are retained.
- flush: clears the FIFO, overflow, underrun_ctr, slot and frame_ok. A frame in progress becomes an underrun at its next_sample. snd_l, snd_r and snd_on are unchanged until then.
- Samples are passed through without width conversion or arithmetic.

Decomposition:
- audio_pkg holds the following:
  - typedef pcm_slot_t (SLOT_LLO, SLOT_LHI, SLOT_RLO, SLOT_RHI).
  - The constant BYTES_PER_FRAME=4.
  - The stereo sample struct {snd_l, snd_r}.
- Sub-module byte_fifo: synchronous single-clock FIFO with registered read, level output, and full/empty flags. It is parameterised by DEPTH_LOG2.

Test Plan:
- Frame assembly: write 34 12 78 56, enable=1, run one frame (4 next_byte then next_sample) -> snd_l=16'h1234, snd_r=16'h5678, snd_on=1, fifo_level=0.
- Underrun to off: empty FIFO, enable=1, run 16 frames -> underrun_ctr=16, snd_on=0 after the 16th frame, snd_l=snd_r=0 (ZERO_ON_OFF=1).
- Partial frame: 3 bytes in FIFO at slot 0 -> no pops, fifo_level stays 3, underrun_ctr+1. Then 1 more byte is written and the next frame plays correctly.
- Overflow: write 1024 bytes, then 1 more -> fifo_full=1, fifo_level=1024, overflow=1. Then flush -> level 0, overflow 0.
- Concurrency: write and slot pop in the same cycle with level=10 -> level stays 10. next_sample and next_byte together -> frame latched, new slot 0 pops.
- Reset mid-frame: rst_n low after 2 pops -> all outputs 0 immediately. After release, 4 writes and one frame give correct samples.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the PCM audio path.
//   pcm_slot_t      : byte position within one 16-bit stereo little-endian frame
//   BYTES_PER_FRAME : bytes in one stereo frame (L lo, L hi, R lo, R hi)
//   stereo_sample_t : one stereo sample pair as driven to the DAC chain
package audio_pkg;

    localparam int BYTES_PER_FRAME = 4;

    typedef enum logic [1:0] {
        SLOT_LLO = 2'd0,
        SLOT_LHI = 2'd1,
        SLOT_RLO = 2'd2,
        SLOT_RHI = 2'd3
    } pcm_slot_t;

    typedef struct packed {
        logic [15:0] snd_l;
        logic [15:0] snd_r;
    } stereo_sample_t;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with registered read data.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO (wins over a same-cycle push/pop)
//   wr_en      : push wr_data (dropped when full)
//   rd_en      : pop; rd_data holds the popped byte from the next clk on
//   level      : bytes currently stored (0 .. 2^DEPTH_LOG2)
//   full/empty : status flags derived from level
module byte_fifo #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push;
    logic                  pop;

    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);
    assign push  = wr_en && !full && !flush;
    assign pop   = rd_en && !empty && !flush;

    // Storage array is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pcm_stream_feeder.sv
// Buffers a host-written 16-bit stereo little-endian PCM byte stream and
// hands whole frames to the DAC chain on its next_byte/next_sample strobes.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   enable              : playback enable
//   flush               : one-cycle pulse, empties FIFO and clears status
//   wr_en, wr_data      : host byte write
//   next_byte           : DAC byte-fetch strobe (four per frame)
//   next_sample         : DAC frame strobe, follows the fourth next_byte
//   snd_l, snd_r        : current signed stereo sample
//   snd_on              : stream active
//   fifo_full           : FIFO full
//   fifo_level          : bytes buffered
//   overflow            : sticky dropped-write flag, cleared by flush
//   underrun_ctr        : saturating underrun frame count, cleared by flush
module pcm_stream_feeder
    import audio_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int OFF_FRAMES  = 16,
    parameter int ZERO_ON_OFF = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  next_byte,
    input  logic                  next_sample,
    output logic [15:0]           snd_l,
    output logic [15:0]           snd_r,
    output logic                  snd_on,
    output logic                  fifo_full,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    output logic [7:0]            underrun_ctr
);

    localparam logic [DEPTH_LOG2:0] FRAME_LEVEL = (DEPTH_LOG2 + 1)'(BYTES_PER_FRAME);
    localparam logic [7:0]          OFF_LIMIT   = 8'(OFF_FRAMES);

    pcm_slot_t      slot, slot_n, pop_slot;
    logic           frame_done, frame_done_n;
    logic           frame_ok, frame_ok_n;
    logic           pop;
    logic           fifo_empty;
    logic [7:0]     rd_data;
    logic           cap_pending;
    pcm_slot_t      cap_slot;
    logic [31:0]    asm_q;
    logic [31:0]    asm_n;
    logic           commit;
    logic [7:0]     off_ctr;
    stereo_sample_t out_q;

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign snd_l  = out_q.snd_l;
    assign snd_r  = out_q.snd_r;

    // A frame commits only if every slot popped and playback is still enabled;
    // a same-cycle flush turns the frame in progress into an underrun.
    assign commit = next_sample && frame_ok && frame_done && enable && !flush;

    // Slot sequencing. next_sample/flush rewind to slot 0 first so that a
    // coincident next_byte is handled as slot 0 of the new frame. The
    // go/no-go decision for the whole frame is taken once, at slot 0, so a
    // short FIFO never consumes part of a frame and breaks byte alignment.
    always_comb begin
        slot_n       = slot;
        frame_done_n = frame_done;
        frame_ok_n   = frame_ok;
        pop_slot     = slot;
        pop          = 1'b0;
        if (flush || next_sample) begin
            slot_n       = SLOT_LLO;
            frame_done_n = 1'b0;
            frame_ok_n   = 1'b0;
        end
        if (next_byte && !frame_done_n) begin
            pop_slot = slot_n;
            if (slot_n == SLOT_LLO) begin
                frame_ok_n = enable && !flush && (fifo_level >= FRAME_LEVEL);
            end
            pop = frame_ok_n && !fifo_empty;
            if (slot_n == SLOT_RHI) begin
                frame_done_n = 1'b1;
            end else begin
                slot_n = pcm_slot_t'(slot_n + 2'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot        <= SLOT_LLO;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            cap_pending <= 1'b0;
            cap_slot    <= SLOT_LLO;
        end else begin
            slot        <= slot_n;
            frame_done  <= frame_done_n;
            frame_ok    <= frame_ok_n;
            cap_pending <= pop;
            cap_slot    <= pop_slot;
        end
    end

    // Read data lands one clk after the pop; folding it in combinationally
    // lets next_sample arrive immediately after the last byte's pop settles.
    always_comb begin
        asm_n = asm_q;
        if (cap_pending) begin
            asm_n[8*cap_slot +: 8] = rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q <= '0;
        end else begin
            asm_q <= asm_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (wr_en && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_ctr <= '0;
        end else if (flush) begin
            underrun_ctr <= '0;
        end else if (next_sample && !commit && underrun_ctr != 8'hFF) begin
            underrun_ctr <= underrun_ctr + 8'd1;
        end
    end

    // Output stage. On underrun the last sample is held until the off
    // counter reaches its limit (or playback is disabled), then the stream
    // is declared off and optionally silenced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            snd_on  <= 1'b0;
            off_ctr <= '0;
        end else if (next_sample) begin
            if (commit) begin
                out_q.snd_l <= asm_n[15:0];
                out_q.snd_r <= asm_n[31:16];
                snd_on      <= 1'b1;
                off_ctr     <= '0;
            end else begin
                if (off_ctr < OFF_LIMIT) begin
                    off_ctr <= off_ctr + 8'd1;
                end
                if (!enable || (off_ctr + 8'd1 >= OFF_LIMIT)) begin
                    snd_on <= 1'b0;
                    if (ZERO_ON_OFF != 0) begin
                        out_q <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pcm_stream_feeder.sv
// Directed self-checking bench for pcm_stream_feeder.
module tb_pcm_stream_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        next_byte = 1'b0;
    logic        next_sample = 1'b0;
    logic [15:0] snd_l;
    logic [15:0] snd_r;
    logic        snd_on;
    logic        fifo_full;
    logic [10:0] fifo_level;
    logic        overflow;
    logic [7:0]  underrun_ctr;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pcm_stream_feeder #(
        .DEPTH_LOG2  (10),
        .OFF_FRAMES  (16),
        .ZERO_ON_OFF (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .next_byte    (next_byte),
        .next_sample  (next_sample),
        .snd_l        (snd_l),
        .snd_r        (snd_r),
        .snd_on       (snd_on),
        .fifo_full    (fifo_full),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .underrun_ctr (underrun_ctr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulseByte();
        next_byte = 1'b1;
        tick();
        next_byte = 1'b0;
        tick();
    endtask

    task automatic pulseSample();
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        tick();
    endtask

    task automatic runFrame();
        for (int i = 0; i < 4; i++) pulseByte();
        pulseSample();
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        checkOutput("rst_snd_l", 32'(snd_l), 32'h0);
        checkOutput("rst_snd_on", 32'(snd_on), 32'h0);
        checkOutput("rst_level", 32'(fifo_level), 32'h0);
        checkOutput("rst_underrun", 32'(underrun_ctr), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Frame assembly
        enable = 1'b1;
        applyStimulus(8'h34); applyStimulus(8'h12);
        applyStimulus(8'h78); applyStimulus(8'h56);
        checkOutput("asm_level_pre", 32'(fifo_level), 32'd4);
        runFrame();
        checkOutput("asm_snd_l", 32'(snd_l), 32'h1234);
        checkOutput("asm_snd_r", 32'(snd_r), 32'h5678);
        checkOutput("asm_snd_on", 32'(snd_on), 32'h1);
        checkOutput("asm_level", 32'(fifo_level), 32'd0);

        // Underrun to off
        for (int f = 0; f < 15; f++) runFrame();
        checkOutput("ur15_snd_on", 32'(snd_on), 32'h1);
        checkOutput("ur15_hold_l", 32'(snd_l), 32'h1234);
        checkOutput("ur15_ctr", 32'(underrun_ctr), 32'd15);
        runFrame();
        checkOutput("ur16_ctr", 32'(underrun_ctr), 32'd16);
        checkOutput("ur16_snd_on", 32'(snd_on), 32'h0);
        checkOutput("ur16_snd_l", 32'(snd_l), 32'h0);
        checkOutput("ur16_snd_r", 32'(snd_r), 32'h0);

        // Partial frame
        applyStimulus(8'hAA); applyStimulus(8'hBB); applyStimulus(8'hCC);
        runFrame();
        checkOutput("part_level", 32'(fifo_level), 32'd3);
        checkOutput("part_ctr", 32'(underrun_ctr), 32'd17);
        applyStimulus(8'hDD);
        runFrame();
        checkOutput("part_snd_l", 32'(snd_l), 32'hBBAA);
        checkOutput("part_snd_r", 32'(snd_r), 32'hDDCC);
        checkOutput("part_snd_on", 32'(snd_on), 32'h1);
        checkOutput("part_level_after", 32'(fifo_level), 32'd0);

        // Overflow and flush
        for (int i = 0; i < 1024; i++) applyStimulus(8'(i));
        checkOutput("ovf_full", 32'(fifo_full), 32'h1);
        checkOutput("ovf_pre", 32'(overflow), 32'h0);
        applyStimulus(8'hEE);
        checkOutput("ovf_level", 32'(fifo_level), 32'd1024);
        checkOutput("ovf_flag", 32'(overflow), 32'h1);
        pulseFlush();
        checkOutput("flush_level", 32'(fifo_level), 32'd0);
        checkOutput("flush_ovf", 32'(overflow), 32'h0);
        checkOutput("flush_ctr", 32'(underrun_ctr), 32'h0);
        checkOutput("flush_full", 32'(fifo_full), 32'h0);

        // Disable: no commit, stream off, FIFO retained
        applyStimulus(8'h11); applyStimulus(8'h22);
        applyStimulus(8'h33); applyStimulus(8'h44);
        enable = 1'b0;
        runFrame();
        checkOutput("dis_snd_on", 32'(snd_on), 32'h0);
        checkOutput("dis_snd_l", 32'(snd_l), 32'h0);
        checkOutput("dis_level", 32'(fifo_level), 32'd4);
        checkOutput("dis_ctr", 32'(underrun_ctr), 32'd1);
        enable = 1'b1;
        runFrame();
        checkOutput("reen_snd_l", 32'(snd_l), 32'h2211);
        checkOutput("reen_snd_r", 32'(snd_r), 32'h4433);

        // Concurrency
        for (int i = 1; i <= 10; i++) applyStimulus(8'(i));
        checkOutput("conc_level10", 32'(fifo_level), 32'd10);
        next_byte = 1'b1; wr_en = 1'b1; wr_data = 8'h0B;
        tick();
        next_byte = 1'b0; wr_en = 1'b0;
        tick();
        checkOutput("conc_wr_pop", 32'(fifo_level), 32'd10);
        for (int i = 0; i < 3; i++) pulseByte();
        checkOutput("conc_level7", 32'(fifo_level), 32'd7);
        pulseByte();
        checkOutput("conc_extra_nb", 32'(fifo_level), 32'd7);
        next_sample = 1'b1; next_byte = 1'b1;
        tick();
        next_sample = 1'b0; next_byte = 1'b0;
        tick();
        checkOutput("conc_ns_l", 32'(snd_l), 32'h0201);
        checkOutput("conc_ns_r", 32'(snd_r), 32'h0403);
        checkOutput("conc_ns_level", 32'(fifo_level), 32'd6);
        for (int i = 0; i < 3; i++) pulseByte();
        pulseSample();
        checkOutput("conc_f2_l", 32'(snd_l), 32'h0605);
        checkOutput("conc_f2_r", 32'(snd_r), 32'h0807);
        checkOutput("conc_f2_level", 32'(fifo_level), 32'd3);
        pulseFlush();

        // Reset mid-frame
        applyStimulus(8'h5A); applyStimulus(8'hA5);
        applyStimulus(8'hC3); applyStimulus(8'h3C);
        pulseByte(); pulseByte();
        checkOutput("mid_level", 32'(fifo_level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_l", 32'(snd_l), 32'h0);
        checkOutput("mid_rst_r", 32'(snd_r), 32'h0);
        checkOutput("mid_rst_on", 32'(snd_on), 32'h0);
        checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(8'hEF); applyStimulus(8'hBE);
        applyStimulus(8'hAD); applyStimulus(8'hDE);
        runFrame();
        checkOutput("post_rst_l", 32'(snd_l), 32'hBEEF);
        checkOutput("post_rst_r", 32'(snd_r), 32'hDEAD);
        checkOutput("post_rst_on", 32'(snd_on), 32'h1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
